// File: rtl/shared_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter_pkg
// Description : Shared types, port index names and a sizing helper for the
//               shared-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_mem_arbiter_pkg;

  // Access tracker: IDLE = nothing outstanding, BUSY = one access in flight
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Port index names used by the cpu top level
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

  // Bits needed to hold values 0..max_val, never less than one
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_mem_arbiter_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority_select
// Description : Combinational grant picker. A starved requestor (lowest index
//               first) beats the fixed priority order; otherwise the highest
//               requesting index wins. No grant while the issue slot is shut.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_select #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] starved,
  input  logic                 slot_open,
  output logic [NUM_PORTS-1:0] gnt
);

  logic found;

  // Pick exactly one winner among the requestors when a slot is open
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (slot_open) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i] && starved[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (!found && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter
// Description : Puts NUM_PORTS requestors onto one single-port memory with a
//               fixed memory latency, one tracked access in flight, fixed
//               priority with a starvation override and per-port stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int NUM_PORTS    = 2,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        stall,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LAT_W = cnt_width(MEM_LATENCY);
  localparam int OWN_W = cnt_width(NUM_PORTS - 1);
  localparam int SW    = cnt_width(STARVE_LIMIT);

  arb_state_e           state;
  logic [LAT_W-1:0]     lat_cnt;
  logic [OWN_W-1:0]     owner;
  logic [SW-1:0]        starve_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] starved;
  logic [OWN_W-1:0]     win_idx;
  logic                 completing;
  logic                 slot_open;
  logic                 issue;

  // The outstanding access finishes this cycle; reset abandons it
  assign completing = (state == ST_BUSY) && (lat_cnt == LAT_W'(MEM_LATENCY));
  assign slot_open  = !reset && ((state == ST_IDLE) || completing);
  assign issue      = |gnt;

  // Starvation mask; a zero limit never marks anyone as starved
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_starved
      assign starved[i] = (STARVE_LIMIT > 0) && (starve_cnt[i] == SW'(STARVE_LIMIT));
    end
  endgenerate

  arb_priority_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_select (
    .req       (req),
    .starved   (starved),
    .slot_open (slot_open),
    .gnt       (gnt)
  );

  // Route the winner's request onto the memory bus; idle bus is all zero
  always_comb begin
    win_idx   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        win_idx   = OWN_W'(i);
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_en = issue;
  assign stall  = reset ? '0 : (req & ~gnt);
  assign rdata  = completing && !reset ? mem_rdata : '0;

  // Completion pulse goes only to the port that owns the access
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rvalid
      assign rvalid[i] = completing && !reset && (owner == OWN_W'(i));
    end
  endgenerate

  // Access tracker: issue starts/restarts the latency count, completion frees it
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      owner   <= '0;
    end else if (issue) begin
      state   <= ST_BUSY;
      lat_cnt <= LAT_W'(1);
      owner   <= win_idx;
    end else if (completing) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
    end else if (state == ST_BUSY) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  // Per-port denial counters; waiting on memory latency does not count
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_starve_cnt
      always_ff @(posedge clock) begin
        if (reset) begin
          starve_cnt[i] <= '0;
        end else if (!req[i] || gnt[i]) begin
          starve_cnt[i] <= '0;
        end else if (slot_open && (starve_cnt[i] != SW'(STARVE_LIMIT))) begin
          starve_cnt[i] <= starve_cnt[i] + SW'(1);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_mem_arbiter
// Description : Scoreboard bench. Three arbiter instances: A (LAT=1,LIMIT=4),
//               B (LAT=3,LIMIT=4), C (LAT=1,LIMIT=0). Stimulus pushes the
//               expected grants and completions; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_mem_arbiter;

  typedef struct {
    int          dut;
    int          cyc;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  stall;
  } gexp_t;

  typedef struct {
    int          dut;
    int          cyc;
    int          port;
    logic        chk;
    logic [31:0] data;
  } rexp_t;

  logic        clk;
  int          cyc;
  int          n_pass;
  int          n_total;
  gexp_t       gq[$];
  rexp_t       rq[$];
  gexp_t       ge;
  rexp_t       re;

  logic        rst       [3];
  logic [1:0]  req       [3];
  logic [1:0]  we        [3];
  logic [63:0] addr      [3];
  logic [63:0] wdata     [3];
  logic [1:0]  gnt       [3];
  logic [1:0]  stall     [3];
  logic [1:0]  rvalid    [3];
  logic [31:0] rdata     [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  shared_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .NUM_PORTS(2), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clock(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .gnt(gnt[0]), .stall(stall[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .mem_en(mem_en[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  shared_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .NUM_PORTS(2), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clock(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .gnt(gnt[1]), .stall(stall[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .mem_en(mem_en[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  shared_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .NUM_PORTS(2), .MEM_LATENCY(1), .STARVE_LIMIT(0)) u_c (
    .clock(clk), .reset(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .gnt(gnt[2]), .stall(stall[2]), .rvalid(rvalid[2]), .rdata(rdata[2]), .mem_en(mem_en[2]),
    .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input int d, input int c, input int p, input logic w,
                        input logic [31:0] a, input logic [31:0] wd, input logic [1:0] st);
    gexp_t e;
    e.dut = d; e.cyc = c; e.port = p; e.we = w; e.addr = a; e.wdata = wd; e.stall = st;
    gq.push_back(e);
  endtask

  task automatic push_r(input int d, input int c, input int p, input logic ck, input logic [31:0] dat);
    rexp_t e;
    e.dut = d; e.cyc = c; e.port = p; e.chk = ck; e.data = dat;
    rq.push_back(e);
  endtask

  // Monitor: every grant and every completion must match the queue head
  always @(negedge clk) begin
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      check("gnt_missing_cycle", 64'(cyc), 64'(gq[0].cyc));
      void'(gq.pop_front());
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      check("rvalid_missing_cycle", 64'(cyc), 64'(rq[0].cyc));
      void'(rq.pop_front());
    end
    for (int k = 0; k < 3; k++) begin
      if (gnt[k] != 2'b00) begin
        if (gq.size() > 0 && gq[0].cyc == cyc && gq[0].dut == k) begin
          ge = gq.pop_front();
          check("gnt_onehot", 64'(gnt[k]), 64'(2'b01 << ge.port));
          check("mem_en", 64'(mem_en[k]), 64'd1);
          check("mem_we", 64'(mem_we[k]), 64'(ge.we));
          check("mem_addr", 64'(mem_addr[k]), 64'(ge.addr));
          if (ge.we) check("mem_wdata", 64'(mem_wdata[k]), 64'(ge.wdata));
          check("stall", 64'(stall[k]), 64'(ge.stall));
        end else begin
          check("gnt_unexpected", 64'(gnt[k]), 64'd0);
        end
      end
      if (rvalid[k] != 2'b00) begin
        if (rq.size() > 0 && rq[0].cyc == cyc && rq[0].dut == k) begin
          re = rq.pop_front();
          check("rvalid_onehot", 64'(rvalid[k]), 64'(2'b01 << re.port));
          if (re.chk) check("rdata", 64'(rdata[k]), 64'(re.data));
        end else begin
          check("rvalid_unexpected", 64'(rvalid[k]), 64'd0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int t;
    int order [10];
    n_pass  = 0;
    n_total = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 2'b00; we[k] = 2'b00;
      addr[k] = '0; wdata[k] = '0; mem_rdata[k] = '0;
    end

    // Reset held two cycles with both ports requesting
    req[0] = 2'b11;
    repeat (2) begin
      @(negedge clk);
      check("reset_gnt", 64'(gnt[0]), 64'd0);
      check("reset_rvalid", 64'(rvalid[0]), 64'd0);
      check("reset_mem_en", 64'(mem_en[0]), 64'd0);
      check("reset_rdata", 64'(rdata[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;
    req[0] = 2'b00;
    tick();

    // Single read on port 0, LAT=1
    t = cyc;
    req[0] = 2'b01; we[0] = 2'b00;
    addr[0] = {32'h0, 32'h10};
    mem_rdata[0] = 32'hDEADBEEF;
    push_g(0, t, 0, 1'b0, 32'h10, 32'h0, 2'b00);
    push_r(0, t + 1, 0, 1'b1, 32'hDEADBEEF);
    tick();
    req[0] = 2'b00;
    repeat (2) tick();

    // Contention, LAT=1, LIMIT=4
    order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    t = cyc;
    req[0] = 2'b11;
    addr[0] = {32'h200, 32'h100};
    mem_rdata[0] = 32'hCAFE0000;
    for (int i = 0; i < 10; i++) begin
      push_g(0, t + i, order[i], 1'b0, (order[i] == 1) ? 32'h200 : 32'h100, 32'h0,
             (order[i] == 1) ? 2'b01 : 2'b10);
      push_r(0, t + i + 1, order[i], 1'b1, 32'hCAFE0000);
    end
    repeat (10) tick();
    req[0] = 2'b00;
    repeat (2) tick();

    // LAT=3: two back-to-back writes from port 1
    t = cyc;
    req[1] = 2'b10; we[1] = 2'b10;
    addr[1] = {32'h40, 32'h0};
    wdata[1] = {32'h11111111, 32'h0};
    push_g(1, t, 1, 1'b1, 32'h40, 32'h11111111, 2'b00);
    push_r(1, t + 3, 1, 1'b0, 32'h0);
    push_g(1, t + 3, 1, 1'b1, 32'h44, 32'h22222222, 2'b00);
    push_r(1, t + 6, 1, 1'b0, 32'h0);
    tick();
    addr[1] = {32'h44, 32'h0};
    wdata[1] = {32'h22222222, 32'h0};
    repeat (2) begin
      @(negedge clk);
      check("lat3_stall_wait", 64'(stall[1]), 64'(2'b10));
      check("lat3_mem_en_wait", 64'(mem_en[1]), 64'd0);
      check("lat3_mem_we_wait", 64'(mem_we[1]), 64'd0);
      tick();
    end
    tick();
    req[1] = 2'b00; we[1] = 2'b00;
    repeat (4) tick();

    // Reset mid-operation, LAT=3
    t = cyc;
    req[1] = 2'b01;
    addr[1] = {32'h0, 32'h80};
    mem_rdata[1] = 32'h12345678;
    push_g(1, t, 0, 1'b0, 32'h80, 32'h0, 2'b00);
    tick();
    rst[1] = 1'b1;
    req[1] = 2'b00;
    tick();
    rst[1] = 1'b0;
    req[1] = 2'b01;
    addr[1] = {32'h0, 32'h84};
    push_g(1, t + 2, 0, 1'b0, 32'h84, 32'h0, 2'b00);
    push_r(1, t + 5, 0, 1'b1, 32'h12345678);
    tick();
    req[1] = 2'b00;
    @(negedge clk);
    check("abandoned_rvalid", 64'(rvalid[1]), 64'd0);
    repeat (4) tick();

    // LIMIT=0: port 0 never wins under contention
    t = cyc;
    req[2] = 2'b11;
    addr[2] = {32'h400, 32'h300};
    mem_rdata[2] = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      push_g(2, t + i, 1, 1'b0, 32'h400, 32'h0, 2'b01);
      push_r(2, t + i + 1, 1, 1'b1, 32'h0BADF00D);
    end
    repeat (10) tick();
    req[2] = 2'b00;
    repeat (3) tick();

    @(negedge clk);
    check("gnt_queue_drained", 64'(gq.size()), 64'd0);
    check("rvalid_queue_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
